result_drain: RTL and testbench
===============================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of array columns drained per frame; legal range 2..64.
REQ-002 SHALL have parameter OUTWIDTH, default 32, result word width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_r  input  unpacked array [0:ROWS-1] of OUTWIDTH  per-column result word from the core output stage.
REQ-006 SHALL have port in_v  input  ROWS (index 0 to ROWS-1)  per-column result-valid from the core output stage.
REQ-007 SHALL have port rread  output  1  results-consumed strobe driven to the core output stage.
REQ-008 SHALL have port out_data  output  OUTWIDTH  serialized result word.
REQ-009 SHALL have port out_col  output  $clog2(ROWS)  column index of out_data.
REQ-010 SHALL have port out_last  output  1  marks the final word of a frame.
REQ-011 SHALL have port out_valid  output  1  stream valid.
REQ-012 SHALL have port out_ready  input  1  stream ready from the downstream consumer.
REQ-013 SHALL have port frame_cnt  output  16  count of fully drained frames.

Function
REQ-014 SHALL implement an FSM with states IDLE and SEND.
REQ-015 In IDLE, when all ROWS bits of in_v are 1: SHALL register every in_r word into a ROWS-entry frame buffer, assert rread for exactly one cycle (the cycle after the capture edge), set the column pointer to 0, and enter SEND.
REQ-016 In IDLE, with any in_v bit at 0 (partial valid): SHALL capture nothing, keep rread at 0, and stay in IDLE.
REQ-017 rread SHALL be a registered single-cycle pulse, asserted once per captured frame and at no other time.
REQ-018 In SEND: out_valid SHALL be 1; out_data SHALL equal buffer[ptr]; out_col SHALL equal ptr; out_last SHALL be 1 only when ptr equals ROWS-1.
REQ-019 A transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; ptr SHALL advance by 1 per transfer.
REQ-020 While out_valid=1 and out_ready=0: out_data, out_col and out_last SHALL hold stable.
REQ-021 On the transfer with out_last=1: SHALL return to IDLE, drop out_valid to 0 the next cycle, and increment frame_cnt by 1 (modulo 2^16).
REQ-022 in_v and in_r SHALL be ignored in SEND; a new frame is captured only from IDLE, earliest in the cycle after the last transfer.
REQ-023 Minimum frame period SHALL be ROWS+1 cycles: 1 capture cycle plus ROWS transfer cycles with out_ready held at 1.
REQ-024 Latency SHALL be 1 cycle: out_valid rises on the clock edge after the cycle in which in_v is all-ones in IDLE.
REQ-025 Buffer contents SHALL remain unchanged from capture until the end of the frame, regardless of in_r changes.

Reset
REQ-026 While rstn=0 at a clock edge: state SHALL become IDLE; rread, out_valid, out_last, out_col, out_data, frame_cnt and ptr SHALL become 0; buffer contents need not be cleared.
REQ-027 Reset asserted during SEND SHALL abandon the frame with no further transfers and no rread pulse; after reset a frame whose in_v is still all-ones SHALL be captured again.

Verification
REQ-028 ROWS=8, in_v=8'hFF, in_r[k]=k+100, out_ready=1 -> rread pulses once; words 100..107 on out_col 0..7 in 8 consecutive cycles; out_last on col 7; frame_cnt=1.
REQ-029 in_v=8'h7F held for 20 cycles -> no rread, out_valid stays 0; then in_v=8'hFF -> capture and rread on the next edge.
REQ-030 Frame in flight, out_ready toggled 1,0,0,1,... -> no word dropped or duplicated; out_data stable across each stall; in_r changed mid-frame does not alter the output.
REQ-031 Back-to-back frames with in_v re-asserted after each rread, out_ready=1 -> frame period 9 cycles; frame_cnt increments per frame; frame_cnt at 16'hFFFF wraps to 0.
REQ-032 rstn=0 for 1 cycle after the word with out_col=3 -> all outputs 0 next cycle; with in_v=8'hFF afterwards a new frame starts at out_col 0 and frame_cnt counts from 0.

Source files
------------

// File: rtl/result_drain.sv
// ----------------------------------------------------------------------------
// result_drain
//
// Purpose:
//   Captures one frame of per-column result words from the core output stage
//   once every column reports valid, acknowledges the capture with a single
//   rread pulse, then serializes the frame column by column onto a
//   valid/ready stream. Counts fully drained frames.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rstn       - synchronous active-low reset
//   in_r       - per-column result words [0:ROWS-1], OUTWIDTH bits each
//   in_v       - per-column result valids [0:ROWS-1]
//   rread      - one-cycle "results consumed" strobe to the core output stage
//   out_data   - serialized result word
//   out_col    - column index of out_data
//   out_last   - final word of the frame
//   out_valid  - stream valid
//   out_ready  - stream ready from the downstream consumer
//   frame_cnt  - number of fully drained frames, wraps modulo 2^16
// ----------------------------------------------------------------------------
module result_drain #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [OUTWIDTH-1:0]       in_r [0:ROWS-1],
    input  logic [0:ROWS-1]           in_v,
    output logic                      rread,
    output logic [OUTWIDTH-1:0]       out_data,
    output logic [$clog2(ROWS)-1:0]   out_col,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               frame_cnt
);

    localparam int              PW       = $clog2(ROWS);
    localparam logic [PW-1:0]   LAST_COL = PW'(ROWS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_capture;
    logic                w_xfer;
    logic                w_last_xfer;

    logic [PW-1:0]       r_ptr;
    logic                r_rread;
    logic [15:0]         r_frame_cnt;
    logic [OUTWIDTH-1:0] r_buf [0:ROWS-1];

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle event decode
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_xfer      = 1'b0;
        w_last_xfer = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A frame is only taken when every column is valid at once;
                // a partially valid array is left for the core to complete.
                if (&in_v) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // in_v / in_r are deliberately not looked at here.
                if (out_ready) begin
                    w_xfer = 1'b1;
                    if (r_ptr == LAST_COL) begin
                        w_last_xfer = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame buffer: written only on capture so the words stay frozen for the
    // whole drain even though in_r keeps moving. Not reset on purpose.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < ROWS; k++) begin
                r_buf[k] <= in_r[k];
            end
        end
    end

    // Column pointer and the rread pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr   <= '0;
            r_rread <= 1'b0;
        end else begin
            // rread is the registered copy of the capture event, so it is high
            // for exactly the first SEND cycle of each frame.
            r_rread <= w_capture;
            if (w_capture || w_last_xfer) begin
                r_ptr <= '0;
            end else if (w_xfer) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Drained-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_frame_cnt <= '0;
        end else if (w_last_xfer) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Stream outputs are decoded from registered state only. Data is gated
    // with valid so the uncleared buffer never shows up outside SEND.
    assign out_valid = (r_state == S_SEND);
    assign out_data  = out_valid ? r_buf[r_ptr] : '0;
    assign out_col   = r_ptr;
    assign out_last  = out_valid && (r_ptr == LAST_COL);
    assign rread     = r_rread;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;

    localparam int ROWS = 8;
    localparam int W    = 32;

    logic           clk = 1'b0;
    logic           rstn;
    logic [W-1:0]   in_r [0:ROWS-1];
    logic [0:ROWS-1] in_v;
    logic           rread;
    logic [W-1:0]   out_data;
    logic [2:0]     out_col;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    frame_cnt;

    int             vectors    = 0;
    int             miscompares = 0;
    logic [15:0]    exp_frames = '0;

    always #5 clk = ~clk;

    result_drain #(.ROWS(ROWS), .OUTWIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_r      (in_r),
        .in_v      (in_v),
        .rread     (rread),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_in_r();
        for (int k = 0; k < ROWS; k++) in_r[k] = $urandom;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        in_v = '1;
        out_ready = 1'b1;
        randomize_in_r();
        step();
        step();
        vectors++;
        if ({rread, out_valid, out_last} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rread/valid/last=%b required 000", {rread, out_valid, out_last});
        end
        vectors++;
        if ({out_col, out_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got col=%0d data=%0h required 0/0", out_col, out_data);
        end
        vectors++;
        if (frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
        end
        exp_frames = '0;
        in_v = '0;
        rstn = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || rread !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got valid=%b rread=%b required 0/0", out_valid, rread);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < ROWS; k++) in_r[k] = W'(k + 100);
        in_v = '1;
        out_ready = 1'b1;
        step();
        in_v = '0;
        for (int k = 0; k < ROWS; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== W'(k + 100) || out_col !== 3'(k)) begin
                miscompares++;
                $display("FAIL basic_word k=%0d: got v=%b data=%0d col=%0d required 1/%0d/%0d",
                         k, out_valid, out_data, out_col, k + 100, k);
            end
            vectors++;
            if (out_last !== (k == ROWS - 1) || rread !== (k == 0)) begin
                miscompares++;
                $display("FAIL basic_flags k=%0d: got last=%b rread=%b required %b/%b",
                         k, out_last, rread, (k == ROWS - 1), (k == 0));
            end
            step();
        end
        exp_frames++;
        vectors++;
        if (out_valid !== 1'b0 || rread !== 1'b0 || frame_cnt !== exp_frames) begin
            miscompares++;
            $display("FAIL basic_end: got valid=%b rread=%b cnt=%0d required 0/0/%0d",
                     out_valid, rread, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_partial_valid();
        logic [W-1:0] fr [0:ROWS-1];
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_v = 8'h7F;
            if (i >= 10) begin
                in_v = '1;
                in_v[$urandom_range(0, ROWS - 1)] = 1'b0;
            end
            randomize_in_r();
            step();
            vectors++;
            if (rread !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL partial_hold i=%0d: got rread=%b valid=%b required 0/0", i, rread, out_valid);
            end
        end
        for (int k = 0; k < ROWS; k++) fr[k] = $urandom;
        in_r = fr;
        in_v = '1;
        step();
        in_v = '0;
        for (int k = 0; k < ROWS; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== fr[k] || out_col !== 3'(k) || rread !== (k == 0)) begin
                miscompares++;
                $display("FAIL partial_drain k=%0d: got v=%b data=%0h col=%0d rread=%b required 1/%0h/%0d/%b",
                         k, out_valid, out_data, out_col, rread, fr[k], k, (k == 0));
            end
            step();
        end
        exp_frames++;
        vectors++;
        if (frame_cnt !== exp_frames) begin
            miscompares++;
            $display("FAIL partial_cnt: got %0d required %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] fr [0:ROWS-1];
        int idx;
        for (int k = 0; k < ROWS; k++) fr[k] = $urandom;
        in_r = fr;
        in_v = '1;
        out_ready = 1'b0;
        step();
        idx = 0;
        for (int c = 0; c < 64 && idx < ROWS; c++) begin
            // ready pattern 1,0,0,1,1,0,0,1,...; inputs scrambled every cycle
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            in_v = ROWS'($urandom);
            randomize_in_r();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== fr[idx] || out_col !== 3'(idx)) begin
                miscompares++;
                $display("FAIL bp_word c=%0d: got v=%b data=%0h col=%0d required 1/%0h/%0d",
                         c, out_valid, out_data, out_col, fr[idx], idx);
            end
            vectors++;
            if (out_last !== (idx == ROWS - 1) || rread !== (c == 0)) begin
                miscompares++;
                $display("FAIL bp_flags c=%0d: got last=%b rread=%b required %b/%b",
                         c, out_last, rread, (idx == ROWS - 1), (c == 0));
            end
            step();
            if (out_ready) idx++;
        end
        in_v = '0;
        exp_frames++;
        vectors++;
        if (idx !== ROWS || out_valid !== 1'b0 || frame_cnt !== exp_frames) begin
            miscompares++;
            $display("FAIL bp_end: got words=%0d valid=%b cnt=%0d required %0d/0/%0d",
                     idx, out_valid, frame_cnt, ROWS, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] frames [0:3][0:ROWS-1];
        int phase;
        int f;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < ROWS; k++) frames[i][k] = $urandom;
        in_r = frames[0];
        in_v = '1;
        out_ready = 1'b1;
        for (int s = 0; s < 36; s++) begin
            step();
            phase = s % 9;
            f = s / 9;
            if (phase < 8) begin
                vectors++;
                if (out_valid !== 1'b1 || out_col !== 3'(phase) || out_data !== frames[f][phase] ||
                    rread !== (phase == 0)) begin
                    miscompares++;
                    $display("FAIL b2b_word s=%0d: got v=%b col=%0d data=%0h rread=%b required 1/%0d/%0h/%b",
                             s, out_valid, out_col, out_data, rread, phase, frames[f][phase], (phase == 0));
                end
                if (phase == 0 && f < 3) in_r = frames[f + 1];
            end else begin
                exp_frames++;
                vectors++;
                if (out_valid !== 1'b0 || rread !== 1'b0 || frame_cnt !== exp_frames) begin
                    miscompares++;
                    $display("FAIL b2b_gap s=%0d: got valid=%b rread=%b cnt=%0d required 0/0/%0d",
                             s, out_valid, rread, frame_cnt, exp_frames);
                end
            end
            if (s == 35) in_v = '0;
        end
    endtask

    task automatic test_frame_cnt_wrap();
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        #1;
        vectors++;
        if (frame_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preset: got %0h required ffff", frame_cnt);
        end
        randomize_in_r();
        in_v = '1;
        out_ready = 1'b1;
        step();
        in_v = '0;
        for (int k = 0; k < ROWS; k++) step();
        exp_frames = 16'd0;
        vectors++;
        if (frame_cnt !== exp_frames || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap: got cnt=%0h valid=%b required 0/0", frame_cnt, out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] fr [0:ROWS-1];
        for (int k = 0; k < ROWS; k++) fr[k] = $urandom;
        in_r = fr;
        in_v = '1;
        out_ready = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_data !== fr[k] || out_col !== 3'(k)) begin
                miscompares++;
                $display("FAIL rstmid_word k=%0d: got data=%0h col=%0d required %0h/%0d",
                         k, out_data, out_col, fr[k], k);
            end
            step();
        end
        // word with col 3 has just transferred; pulse reset for one edge
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        exp_frames = '0;
        vectors++;
        if ({rread, out_valid, out_last, out_col, out_data, frame_cnt} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_zero: got rread=%b v=%b last=%b col=%0d data=%0h cnt=%0d required all 0",
                     rread, out_valid, out_last, out_col, out_data, frame_cnt);
        end
        for (int k = 0; k < ROWS; k++) fr[k] = $urandom;
        in_r = fr;
        step();
        in_v = '0;
        for (int k = 0; k < ROWS; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== fr[k] || out_col !== 3'(k) || rread !== (k == 0)) begin
                miscompares++;
                $display("FAIL rstmid_refill k=%0d: got v=%b data=%0h col=%0d rread=%b required 1/%0h/%0d/%b",
                         k, out_valid, out_data, out_col, rread, fr[k], k, (k == 0));
            end
            step();
        end
        exp_frames++;
        vectors++;
        if (frame_cnt !== exp_frames || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_cnt: got cnt=%0d valid=%b required %0d/0", frame_cnt, out_valid, exp_frames);
        end
    endtask

    // Transaction-level model: a queue of words still owed to the stream.
    // A frame is owed whenever the queue is empty and all columns are valid;
    // each accepted word removes the head of the queue.
    task automatic test_random();
        logic [W-1:0] q [$];
        logic         exp_rread;
        int           sz;
        for (int c = 0; c < 400; c++) begin
            in_v = '1;
            if ($urandom_range(0, 2) == 0) in_v[$urandom_range(0, ROWS - 1)] = 1'b0;
            randomize_in_r();
            out_ready = ($urandom_range(0, 3) != 0);
            exp_rread = 1'b0;
            if (q.size() == 0) begin
                if (&in_v) begin
                    for (int k = 0; k < ROWS; k++) q.push_back(in_r[k]);
                    exp_rread = 1'b1;
                end
            end else if (out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) exp_frames++;
            end
            step();
            sz = q.size();
            vectors++;
            if (out_valid !== (sz != 0) || rread !== exp_rread || frame_cnt !== exp_frames) begin
                miscompares++;
                $display("FAIL rand_ctrl c=%0d: got v=%b rread=%b cnt=%0d required %b/%b/%0d",
                         c, out_valid, rread, frame_cnt, (sz != 0), exp_rread, exp_frames);
            end
            if (sz != 0) begin
                vectors++;
                if (out_data !== q[0] || out_col !== 3'(ROWS - sz) || out_last !== (sz == 1)) begin
                    miscompares++;
                    $display("FAIL rand_word c=%0d: got data=%0h col=%0d last=%b required %0h/%0d/%b",
                             c, out_data, out_col, out_last, q[0], ROWS - sz, (sz == 1));
                end
            end
        end
        // let any frame in flight finish
        in_v = '0;
        out_ready = 1'b1;
        while (q.size() != 0) begin
            void'(q.pop_front());
            if (q.size() == 0) exp_frames++;
            step();
        end
        vectors++;
        if (out_valid !== 1'b0 || frame_cnt !== exp_frames) begin
            miscompares++;
            $display("FAIL rand_end: got v=%b cnt=%0d required 0/%0d", out_valid, frame_cnt, exp_frames);
        end
    endtask

    initial begin
        rstn = 1'b0;
        in_v = '0;
        out_ready = 1'b0;
        for (int k = 0; k < ROWS; k++) in_r[k] = '0;
        #2;
        test_reset();
        test_basic();
        test_partial_valid();
        test_backpressure();
        test_back_to_back();
        test_frame_cnt_wrap();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
